// File: rtl/ws_pkg.sv
// ----------------------------------------------------------------------------
// ws_pkg: shared WS2812 state encoding, word width and 50 MHz timing defaults.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ws_pkg;

  localparam int GRB_W = 24;

  localparam int DEF_T0H     = 20;
  localparam int DEF_T1H     = 40;
  localparam int DEF_T_BIT   = 63;
  localparam int DEF_T_RESET = 2750;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BIT   = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ws_bit_timer.sv
// ----------------------------------------------------------------------------
// ws_bit_timer: one WS2812 bit period, registered high/low level plus bitEnd.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ws_bit_timer
  import ws_pkg::*;
#(
  parameter int T0H   = DEF_T0H,
  parameter int T1H   = DEF_T1H,
  parameter int T_BIT = DEF_T_BIT,
  parameter int CNT_W = $clog2(T_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bitVal,
  output logic dout,
  output logic bitEnd
);

  localparam logic [CNT_W-1:0] C_T0H  = CNT_W'(T0H);
  localparam logic [CNT_W-1:0] C_T1H  = CNT_W'(T1H);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(T_BIT - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             dout_q, dout_d;

  assign bitEnd = active_q && (cnt_q == C_LAST);
  assign dout   = dout_q;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    // dout lags the counter by one cycle so the line is glitch-free from a flop
    dout_d   = active_q && (cnt_q < (bitVal ? C_T1H : C_T0H));
    if (start) begin
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (bitEnd) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + C_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      dout_q   <= dout_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/grb_shipper.sv
// ----------------------------------------------------------------------------
// grb_shipper: WS2812 frame serializer with one-word prefetch and latch delay.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module grb_shipper
  import ws_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T_RESET  = DEF_T_RESET,
  localparam int ADDR_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shipGRB,
  output logic [ADDR_W-1:0] ledAddr,
  input  logic [GRB_W-1:0]  grbData,
  output logic              dout,
  output logic              Done,
  output logic              allDone
);

  localparam int CNT_W = $clog2((T_BIT > T_RESET) ? T_BIT : T_RESET);

  localparam logic [ADDR_W-1:0] C_LED_LAST = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] C_LED_ONE  = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  C_RST_LAST = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0]  C_CNT_ONE  = CNT_W'(1);
  localparam logic [4:0]        C_BIT_TOP  = 5'd23;

  state_t              state_q, state_d;
  logic [GRB_W-1:0]    shift_q, shift_d;
  logic [GRB_W-1:0]    next_q, next_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   led_cnt_q, led_cnt_d;
  logic [ADDR_W-1:0]   led_addr_q, led_addr_d;
  logic [CNT_W-1:0]    latch_cnt_q, latch_cnt_d;
  logic                load_q, load_d;
  logic                done_q, done_d;
  logic                all_done_q, all_done_d;
  logic                start_bit;
  logic                bit_end;

  assign ledAddr = led_addr_q;
  assign Done    = done_q;
  assign allDone = all_done_q;

  ws_bit_timer #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start_bit),
    .bitVal (shift_q[GRB_W-1]),
    .dout   (dout),
    .bitEnd (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    next_d      = next_q;
    bit_cnt_d   = bit_cnt_q;
    led_cnt_d   = led_cnt_q;
    led_addr_d  = led_addr_q;
    latch_cnt_d = latch_cnt_q;
    load_d      = 1'b0;
    done_d      = 1'b0;
    all_done_d  = 1'b0;
    start_bit   = 1'b0;

    // Address advances one cycle after a load, in step with the delayed dout
    if (load_q && (led_cnt_q != C_LED_LAST)) begin
      led_addr_d = led_cnt_q + C_LED_ONE;
    end

    case (state_q)
      IDLE: begin
        led_addr_d = '0;
        if (shipGRB) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        shift_d   = grbData;
        bit_cnt_d = C_BIT_TOP;
        led_cnt_d = '0;
        load_d    = 1'b1;
        start_bit = 1'b1;
        state_d   = BIT;
      end
      BIT: begin
        if (bit_end) begin
          if ((bit_cnt_q == C_BIT_TOP) && (led_cnt_q != C_LED_LAST)) begin
            next_d = grbData;
          end
          if (bit_cnt_q != 5'd0) begin
            shift_d   = {shift_q[GRB_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
            start_bit = 1'b1;
          end else if (led_cnt_q != C_LED_LAST) begin
            shift_d   = next_q;
            bit_cnt_d = C_BIT_TOP;
            led_cnt_d = led_cnt_q + C_LED_ONE;
            load_d    = 1'b1;
            start_bit = 1'b1;
          end else begin
            latch_cnt_d = '0;
            state_d     = LATCH;
          end
        end
      end
      LATCH: begin
        done_d = (latch_cnt_q == '0);
        if (latch_cnt_q == C_RST_LAST) begin
          all_done_d  = 1'b1;
          latch_cnt_d = '0;
          led_addr_d  = '0;
          state_d     = IDLE;
        end else begin
          latch_cnt_d = latch_cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      next_q      <= '0;
      bit_cnt_q   <= '0;
      led_cnt_q   <= '0;
      led_addr_q  <= '0;
      latch_cnt_q <= '0;
      load_q      <= 1'b0;
      done_q      <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      next_q      <= next_d;
      bit_cnt_q   <= bit_cnt_d;
      led_cnt_q   <= led_cnt_d;
      led_addr_q  <= led_addr_d;
      latch_cnt_q <= latch_cnt_d;
      load_q      <= load_d;
      done_q      <= done_d;
      all_done_q  <= all_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_grb_shipper.sv
// ----------------------------------------------------------------------------
// tb_grb_shipper: directed frame vectors for grb_shipper (2-LED and 1-LED).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_grb_shipper;

  typedef struct {
    logic [23:0] w0;
    logic [23:0] w1;
    int          exp_hi;
    bit          hold;
    bit          corrupt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ship = 1'b0;
  logic        ship1 = 1'b0;
  logic        ledAddr, ledAddr1;
  logic [23:0] grbData, grbData1;
  logic        dout, Done, allDone;
  logic        dout1, Done1, allDone1;
  logic [23:0] mem [2];
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [4];

  always #5 clk = ~clk;

  always @(posedge clk) grbData <= mem[ledAddr];

  grb_shipper #(.NUM_LEDS(2), .T0H(2), .T1H(4), .T_BIT(6), .T_RESET(10)) dut (
    .clk(clk), .reset(reset), .shipGRB(ship), .ledAddr(ledAddr),
    .grbData(grbData), .dout(dout), .Done(Done), .allDone(allDone)
  );

  grb_shipper #(.NUM_LEDS(1), .T0H(2), .T1H(4), .T_BIT(6), .T_RESET(10)) dut1 (
    .clk(clk), .reset(reset), .shipGRB(ship1), .ledAddr(ledAddr1),
    .grbData(grbData1), .dout(dout1), .Done(Done1), .allDone(allDone1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Six samples of one bit period, first sample in bit 5
  function automatic int classify(input logic [5:0] p);
    if (p === 6'b111100) return 1;
    if (p === 6'b110000) return 0;
    return -1;
  endfunction

  task automatic run_frame(input vec_t v);
    logic [5:0]  per;
    logic [23:0] rx0, rx1;
    int hi_total, bad_shape, bad_addr, bad_flag, done_at, all_at, flag_cnt, s, b, idx, k, low_bad;
    per = '0; rx0 = '0; rx1 = '0;
    hi_total = 0; bad_shape = 0; bad_addr = 0; bad_flag = 0;
    done_at = -1; all_at = -1; flag_cnt = 0; low_bad = 0;
    mem[0] = v.w0;
    mem[1] = v.w1;
    repeat (3) @(negedge clk);
    ship = 1'b1;
    @(negedge clk);
    if (!v.hold) ship = 1'b0;
    chk("dout_low_after_t", {31'd0, dout}, 0);
    @(negedge clk);
    chk("dout_low_after_t1", {31'd0, dout}, 0);
    chk("addr_before_t2", {31'd0, ledAddr}, 0);
    @(negedge clk);
    chk("dout_rise_t2", {31'd0, dout}, 1);
    chk("addr_at_t2", {31'd0, ledAddr}, 1);
    if (v.corrupt) mem[0] = ~v.w0;
    for (s = 0; s < 288; s++) begin
      per = {per[4:0], dout};
      if (dout === 1'b1) hi_total++;
      if (ledAddr !== 1'b1) bad_addr++;
      if (Done !== 1'b0 || allDone !== 1'b0) bad_flag++;
      if (s % 6 == 5) begin
        idx = s / 6;
        b = classify(per);
        if (b < 0) bad_shape++;
        if (idx < 24) rx0[23 - idx] = (b == 1);
        else          rx1[23 - (idx - 24)] = (b == 1);
      end
      @(negedge clk);
    end
    for (s = 288; s < 298; s++) begin
      if (Done === 1'b1) begin flag_cnt++; if (done_at < 0) done_at = s; end
      if (allDone === 1'b1) begin flag_cnt++; if (all_at < 0) all_at = s; end
      if (dout !== 1'b0) low_bad++;
      @(negedge clk);
    end
    chk("led0_word", rx0, v.w0);
    chk("led1_word", rx1, v.w1);
    chk("high_cycles", hi_total, v.exp_hi);
    chk("bad_bit_shapes", bad_shape, 0);
    chk("addr_not_held", bad_addr, 0);
    chk("early_flags", bad_flag, 0);
    chk("done_sample", done_at, 288);
    chk("alldone_sample", all_at, 297);
    chk("flag_pulse_count", flag_cnt, 2);
    chk("latch_dout_low", low_bad, 0);
    if (v.hold) begin
      while (dout !== 1'b1 && s < 400) begin
        @(negedge clk);
        s++;
      end
      chk("b2b_rise_sample", s, 300);
      ship = 1'b0;
      k = 0;
      while (allDone !== 1'b1 && k < 400) begin
        @(negedge clk);
        k++;
      end
      chk("b2b_alldone_seen", {31'd0, allDone}, 1);
      repeat (3) @(negedge clk);
      chk("b2b_idle_addr", {31'd0, ledAddr}, 0);
    end else begin
      chk("idle_addr", {31'd0, ledAddr}, 0);
      low_bad = 0;
      repeat (6) begin
        if (dout !== 1'b0) low_bad++;
        @(negedge clk);
      end
      chk("idle_no_restart", low_bad, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [5:0]  per;
    logic [23:0] rx;
    int bad_shape, bad_addr, b;

    vecs[0] = '{w0: 24'hFF0000, w1: 24'h00000F, exp_hi: 120, hold: 1'b0, corrupt: 1'b0};
    vecs[1] = '{w0: 24'h000000, w1: 24'hFFFFFF, exp_hi: 144, hold: 1'b0, corrupt: 1'b1};
    vecs[2] = '{w0: 24'hA5C3F0, w1: 24'h0F0F0F, exp_hi: 144, hold: 1'b1, corrupt: 1'b0};
    vecs[3] = '{w0: 24'h123456, w1: 24'h89ABCD, exp_hi: 140, hold: 1'b0, corrupt: 1'b0};

    mem[0] = '0;
    mem[1] = '0;
    grbData1 = 24'hAAAAAA;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("reset_idle_outputs",
          {24'd0, dout, Done, allDone, ledAddr, dout1, Done1, allDone1, ledAddr1}, 0);
    end

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset during LED 0, bit 10 (bit period 13, second cycle)
    mem[0] = 24'hFF0000;
    mem[1] = 24'h00000F;
    repeat (3) @(negedge clk);
    ship = 1'b1;
    @(negedge clk);
    ship = 1'b0;
    repeat (2) @(negedge clk);
    repeat (79) @(negedge clk);
    chk("pre_reset_dout", {31'd0, dout}, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_dout", {31'd0, dout}, 0);
    chk("async_reset_addr", {31'd0, ledAddr}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (400) begin
      if (Done !== 1'b0 || allDone !== 1'b0 || dout !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("no_activity_after_reset", cnt, 0);
    run_frame(vecs[3]);

    // Single-LED instance
    ship1 = 1'b1;
    @(negedge clk);
    ship1 = 1'b0;
    @(negedge clk);
    chk("n1_dout_low_t1", {31'd0, dout1}, 0);
    @(negedge clk);
    chk("n1_dout_rise", {31'd0, dout1}, 1);
    per = '0; rx = '0; bad_shape = 0; bad_addr = 0;
    for (int s = 0; s < 144; s++) begin
      per = {per[4:0], dout1};
      if (ledAddr1 !== 1'b0) bad_addr++;
      if (Done1 !== 1'b0) bad_addr++;
      if (s % 6 == 5) begin
        b = classify(per);
        if (b < 0) bad_shape++;
        rx[23 - s / 6] = (b == 1);
      end
      @(negedge clk);
    end
    chk("n1_word", rx, 24'hAAAAAA);
    chk("n1_bad_shapes", bad_shape, 0);
    chk("n1_addr_or_early_done", bad_addr, 0);
    chk("n1_done", {31'd0, Done1}, 1);
    repeat (9) @(negedge clk);
    chk("n1_alldone", {31'd0, allDone1}, 1);
    @(negedge clk);
    chk("n1_alldone_one_cycle", {31'd0, allDone1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
